// File: rtl/gfx_pkg.sv
// ---------------------------------------------------------------------------
// gfx_pkg
// Shared definitions for the graphics block: VRAM bus widths (shared with the
// VGA generator), CPU-side register map of the VRAM write port, the write-port
// state encoding and a helper to decode the fill length.
// ---------------------------------------------------------------------------
package gfx_pkg;

    // VRAM bus geometry: 64 KB, byte wide
    localparam int GFX_VRAM_ADDR_W = 16;
    localparam int GFX_VRAM_DATA_W = 8;

    // Fill counter holds 1..256, so it needs one bit more than a byte
    localparam int GFX_FILL_CNT_W = 9;

    // CPU register map of the VRAM write port
    localparam logic [1:0] GFX_WR_ADDR_LO = 2'd0;
    localparam logic [1:0] GFX_WR_ADDR_HI = 2'd1;
    localparam logic [1:0] GFX_WR_DATA    = 2'd2;
    localparam logic [1:0] GFX_WR_FILL    = 2'd3;

    // Write-port sequencing state
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN_WAIT = 2'd1,
        FILL       = 2'd2
    } gfx_wr_state_t;

    // A fill length byte of zero encodes the maximum run of 256 writes
    function automatic logic [GFX_FILL_CNT_W-1:0] gfx_fill_len(input logic [7:0] code);
        logic [GFX_FILL_CNT_W-1:0] len;
        if (code == 8'd0) begin
            len = 9'd256;
        end else begin
            len = {1'b0, code};
        end
        return len;
    endfunction

endpackage

// File: rtl/gfx_wfifo.sv
// ---------------------------------------------------------------------------
// gfx_wfifo
// Small synchronous FIFO of packed {addr,data} VRAM write entries. The head
// entry is presented combinationally from registered storage. A pop in the
// same cycle as a push on a full FIFO frees the slot first, so the push is
// accepted.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset (empties the FIFO)
//   push       enqueue push_data this cycle
//   push_data  entry to enqueue
//   pop        dequeue the head entry this cycle
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   head       oldest entry (valid while !empty)
// ---------------------------------------------------------------------------
module gfx_wfifo #(
    parameter int DEPTH = 4,   // power of two, minimum 2
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == CNT_ZERO);
    assign head  = mem_r[rd_ptr_r];

    // Pop is evaluated first so a simultaneous pop makes room on a full FIFO
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Entry storage; contents need no reset because occupancy is tracked by count_r
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gfx_vram_writer.sv
// ---------------------------------------------------------------------------
// gfx_vram_writer
// CPU-to-VRAM write port on the shared VRAM bus. CPU byte writes and block
// fills are queued and committed only in cycles the VGA generator reports the
// bus free, so CPU traffic never collides with scan-out fetches.
//
// The ADDR_LO/ADDR_HI registers split the address into two bytes, so ADDR_W
// is expected to stay 16 and DATA_W to stay 8.
//
// Ports:
//   i_clk        pixel clock, shared with the VGA generator
//   i_rst        synchronous active-high reset
//   i_ctrl_we    register write strobe (single cycle)
//   i_ctrl_addr  register select: ADDR_LO, ADDR_HI, DATA, FILL
//   i_ctrl_data  register write data
//   i_free_vbus  VRAM bus free this cycle
//   o_vaddr      VRAM address, high-impedance when not driving
//   o_vdata      VRAM write data, high-impedance when not driving
//   o_vwe_b      VRAM write enable, active low, second half-cycle only
//   o_busy       work queued or a fill pending/active
//   o_fifo_full  write queue full
//   o_overflow   sticky: a write was dropped (cleared by an ADDR_HI write)
// ---------------------------------------------------------------------------
module gfx_vram_writer
    import gfx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = GFX_VRAM_ADDR_W,
    parameter int DATA_W     = GFX_VRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ctrl_we,
    input  logic [1:0]        i_ctrl_addr,
    input  logic [7:0]        i_ctrl_data,
    input  logic              i_free_vbus,
    output logic [ADDR_W-1:0] o_vaddr,
    output logic [DATA_W-1:0] o_vdata,
    output logic              o_vwe_b,
    output logic              o_busy,
    output logic              o_fifo_full,
    output logic              o_overflow
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0]         ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [GFX_FILL_CNT_W-1:0] CNT_ONE  = {{(GFX_FILL_CNT_W-1){1'b0}}, 1'b1};

    gfx_wr_state_t               state_r;
    gfx_wr_state_t               state_next_s;
    logic [ADDR_W-1:0]           addr_r;
    logic [ADDR_W-1:0]           addr_next_s;
    logic [DATA_W-1:0]           data_r;
    logic [DATA_W-1:0]           data_next_s;
    logic [GFX_FILL_CNT_W-1:0]   fill_cnt_r;
    logic [GFX_FILL_CNT_W-1:0]   fill_next_s;
    logic                        overflow_r;
    logic                        overflow_next_s;

    logic                        push_s;
    logic [ENTRY_W-1:0]          push_data_s;
    logic                        pop_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [ENTRY_W-1:0]          head_s;
    logic                        can_push_s;
    logic                        drive_s;

    gfx_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wfifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    // Reset gates the drive so the bus is released in the cycle reset is sampled
    assign drive_s    = i_free_vbus && !fifo_empty_s && !i_rst;
    assign pop_s      = drive_s;
    assign can_push_s = !fifo_full_s || pop_s;

    assign o_vaddr     = drive_s ? head_s[ENTRY_W-1:DATA_W] : {ADDR_W{1'bz}};
    assign o_vdata     = drive_s ? head_s[DATA_W-1:0]       : {DATA_W{1'bz}};
    // Address/data settle in the first half; the write strobe only covers the low phase
    assign o_vwe_b     = ~(drive_s && ~i_clk);
    assign o_busy      = !fifo_empty_s || (state_r != IDLE);
    assign o_fifo_full = fifo_full_s;
    assign o_overflow  = overflow_r;

    // Register decode, push generation and sequencing of the fill state machine
    always_comb begin
        state_next_s    = state_r;
        addr_next_s     = addr_r;
        data_next_s     = data_r;
        fill_next_s     = fill_cnt_r;
        overflow_next_s = overflow_r;
        push_s          = 1'b0;
        push_data_s     = {addr_r, data_r};

        if (i_ctrl_we) begin
            case (i_ctrl_addr)
                GFX_WR_ADDR_LO: begin
                    addr_next_s[7:0] = i_ctrl_data;
                end
                GFX_WR_ADDR_HI: begin
                    addr_next_s[15:8] = i_ctrl_data;
                    overflow_next_s   = 1'b0;
                end
                GFX_WR_DATA: begin
                    if (state_r == IDLE) begin
                        data_next_s = i_ctrl_data;
                        push_data_s = {addr_r, i_ctrl_data};
                        // The address advances even when the push is dropped
                        addr_next_s = addr_r + ADDR_ONE;
                        if (can_push_s) begin
                            push_s = 1'b1;
                        end else begin
                            overflow_next_s = 1'b1;
                        end
                    end else begin
                        overflow_next_s = 1'b1;
                    end
                end
                GFX_WR_FILL: begin
                    if (state_r == IDLE) begin
                        fill_next_s  = gfx_fill_len(i_ctrl_data);
                        state_next_s = DRAIN_WAIT;
                    end else begin
                        overflow_next_s = 1'b1;
                    end
                end
                default: begin
                    overflow_next_s = overflow_r;
                end
            endcase
        end else begin
            overflow_next_s = overflow_r;
        end

        case (state_r)
            IDLE: begin
                fill_next_s = fill_next_s;
            end
            DRAIN_WAIT: begin
                // Fill only starts once earlier queued writes are out, keeping order
                if (fifo_empty_s) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = DRAIN_WAIT;
                end
            end
            FILL: begin
                if (can_push_s) begin
                    push_s      = 1'b1;
                    push_data_s = {addr_r, data_r};
                    addr_next_s = addr_r + ADDR_ONE;
                    fill_next_s = fill_cnt_r - CNT_ONE;
                    if (fill_cnt_r == CNT_ONE) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = FILL;
                    end
                end else begin
                    state_next_s = FILL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and register file update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            fill_cnt_r <= {GFX_FILL_CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            addr_r     <= addr_next_s;
            data_r     <= data_next_s;
            fill_cnt_r <= fill_next_s;
            overflow_r <= overflow_next_s;
        end
    end

endmodule

// File: tb/tb_gfx_vram_writer.sv
// ---------------------------------------------------------------------------
// tb_gfx_vram_writer
// Directed self-checking bench for gfx_vram_writer. The VRAM bus nets pull
// low when nobody drives them, so a released bus reads back as zero.
// ---------------------------------------------------------------------------
module tb_gfx_vram_writer;

    logic        i_clk;
    logic        i_rst;
    logic        i_ctrl_we;
    logic [1:0]  i_ctrl_addr;
    logic [7:0]  i_ctrl_data;
    logic        i_free_vbus;
    tri0  [15:0] o_vaddr;
    tri0  [7:0]  o_vdata;
    logic        o_vwe_b;
    logic        o_busy;
    logic        o_fifo_full;
    logic        o_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    gfx_vram_writer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (16),
        .DATA_W     (8)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ctrl_we   (i_ctrl_we),
        .i_ctrl_addr (i_ctrl_addr),
        .i_ctrl_data (i_ctrl_data),
        .i_free_vbus (i_free_vbus),
        .o_vaddr     (o_vaddr),
        .o_vdata     (o_vdata),
        .o_vwe_b     (o_vwe_b),
        .o_busy      (o_busy),
        .o_fifo_full (o_fifo_full),
        .o_overflow  (o_overflow)
    );

    // 10 ns clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Move into the low phase of the current cycle
    task automatic lowph();
        @(negedge i_clk);
        #1;
    endtask

    // One register write, strobe held for exactly one rising edge
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        i_ctrl_we   = 1'b1;
        i_ctrl_addr = a;
        i_ctrl_data = d;
        tick();
        i_ctrl_we   = 1'b0;
    endtask

    logic [15:0] exp_a2 [4];
    logic [15:0] exp_a4 [5];
    logic [7:0]  exp_d4 [5];
    int cyc;
    int ncommit;
    int last;

    initial begin
        exp_a2[0] = 16'hFFFE; exp_a2[1] = 16'hFFFF; exp_a2[2] = 16'h0000; exp_a2[3] = 16'h0001;
        exp_a4[0] = 16'h0300; exp_a4[1] = 16'h0301; exp_a4[2] = 16'h0302;
        exp_a4[3] = 16'h0303; exp_a4[4] = 16'h0304;
        exp_d4[0] = 8'h11; exp_d4[1] = 8'h22; exp_d4[2] = 8'h22;
        exp_d4[3] = 8'h22; exp_d4[4] = 8'h22;

        i_rst       = 1'b1;
        i_ctrl_we   = 1'b0;
        i_ctrl_addr = 2'd0;
        i_ctrl_data = 8'h00;
        i_free_vbus = 1'b0;
        repeat (2) tick();
        i_rst = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_full", {31'd0, o_fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, o_overflow}, 32'd0);
        check("rst_vwe_hi", {31'd0, o_vwe_b}, 32'd1);
        check("rst_vaddr", {16'd0, o_vaddr}, 32'h0);
        check("rst_vdata", {24'd0, o_vdata}, 32'h0);
        lowph();
        check("rst_vwe_lo", {31'd0, o_vwe_b}, 32'd1);
        tick();

        // 1. Single write, committed the cycle after the push
        wr(2'd0, 8'h34);
        wr(2'd1, 8'h12);
        i_free_vbus = 1'b1;
        wr(2'd2, 8'hAA);
        check("t1_vaddr", {16'd0, o_vaddr}, 32'h1234);
        check("t1_vdata", {24'd0, o_vdata}, 32'hAA);
        check("t1_vwe_firsthalf", {31'd0, o_vwe_b}, 32'd1);
        lowph();
        check("t1_vwe_secondhalf", {31'd0, o_vwe_b}, 32'd0);
        check("t1_vaddr_lo", {16'd0, o_vaddr}, 32'h1234);
        tick();
        check("t1_busy_after", {31'd0, o_busy}, 32'd0);
        check("t1_vaddr_rel", {16'd0, o_vaddr}, 32'h0);
        check("t1_vdata_rel", {24'd0, o_vdata}, 32'h0);
        lowph();
        check("t1_vwe_rel", {31'd0, o_vwe_b}, 32'd1);
        tick();

        // 2. Blocked bus: fill the queue, overflow on the fifth, then drain with wrap
        i_free_vbus = 1'b0;
        wr(2'd0, 8'hFE);
        wr(2'd1, 8'hFF);
        for (int d = 1; d <= 4; d++) begin
            wr(2'd2, 8'(d));
        end
        check("t2_full", {31'd0, o_fifo_full}, 32'd1);
        check("t2_ovf_before", {31'd0, o_overflow}, 32'd0);
        wr(2'd2, 8'h05);
        check("t2_ovf_after", {31'd0, o_overflow}, 32'd1);
        check("t2_full_after", {31'd0, o_fifo_full}, 32'd1);
        i_free_vbus = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lowph();
            check("t2_commit_addr", {16'd0, o_vaddr}, {16'd0, exp_a2[i]});
            check("t2_commit_data", {24'd0, o_vdata}, 32'(i + 1));
            check("t2_commit_vwe", {31'd0, o_vwe_b}, 32'd0);
            tick();
        end
        check("t2_busy_drained", {31'd0, o_busy}, 32'd0);
        check("t2_ovf_sticky", {31'd0, o_overflow}, 32'd1);
        lowph();
        check("t2_vwe_drained", {31'd0, o_vwe_b}, 32'd1);
        tick();
        wr(2'd1, 8'h00);
        check("t2_ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // 3. 256-entry fill at 0x0100 with the bus free every other clock
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h55);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        check("t3_idle_before_fill", {31'd0, o_busy}, 32'd0);
        i_free_vbus = 1'b0;
        wr(2'd3, 8'h00);
        cyc = 0;
        ncommit = 0;
        last = -1;
        while (o_busy && cyc < 800) begin
            i_free_vbus = ~i_free_vbus;
            lowph();
            if (!o_vwe_b) begin
                check("t3_fill_addr", {16'd0, o_vaddr}, 32'h0100 + 32'(ncommit));
                check("t3_fill_data", {24'd0, o_vdata}, 32'h55);
                if (ncommit > 0) begin
                    check("t3_fill_spacing", 32'(cyc - last), 32'd2);
                end
                last = cyc;
                ncommit++;
            end
            tick();
            cyc++;
        end
        check("t3_timeout", {31'd0, o_busy}, 32'd0);
        check("t3_fill_count", 32'(ncommit), 32'd256);
        check("t3_busy_drop", 32'(last), 32'(cyc - 1));

        // 4. Fill queued behind pending data; a DATA write during the fill is dropped
        i_free_vbus = 1'b0;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h03);
        wr(2'd2, 8'h11);
        wr(2'd2, 8'h22);
        wr(2'd3, 8'h03);
        check("t4_ovf_before", {31'd0, o_overflow}, 32'd0);
        wr(2'd2, 8'h99);
        check("t4_ovf_data_in_fill", {31'd0, o_overflow}, 32'd1);
        repeat (8) tick();
        check("t4_busy_blocked", {31'd0, o_busy}, 32'd1);
        i_free_vbus = 1'b1;
        ncommit = 0;
        for (int c = 0; c < 40; c++) begin
            lowph();
            if (!o_vwe_b) begin
                if (ncommit < 5) begin
                    check("t4_commit_addr", {16'd0, o_vaddr}, {16'd0, exp_a4[ncommit]});
                    check("t4_commit_data", {24'd0, o_vdata}, {24'd0, exp_d4[ncommit]});
                end
                ncommit++;
            end
            tick();
        end
        check("t4_commit_count", 32'(ncommit), 32'd5);
        check("t4_busy_done", {31'd0, o_busy}, 32'd0);

        // 5. Reset in the middle of a 200-entry fill
        wr(2'd1, 8'h03);
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h77);
        repeat (2) tick();
        wr(2'd3, 8'hC8);
        wr(2'd3, 8'h01);
        check("t5_ovf_fill_in_fill", {31'd0, o_overflow}, 32'd1);
        ncommit = 0;
        for (int c = 0; c < 60; c++) begin
            lowph();
            if (!o_vwe_b) begin
                check("t5_fill_addr", {16'd0, o_vaddr}, 32'h0400 + 32'(ncommit));
                ncommit++;
            end
            if (ncommit == 10) begin
                break;
            end
            tick();
        end
        check("t5_commits_before_rst", 32'(ncommit), 32'd10);
        tick();
        i_rst = 1'b1;
        #1;
        check("t5_rst_vaddr", {16'd0, o_vaddr}, 32'h0);
        check("t5_rst_vwe_hi", {31'd0, o_vwe_b}, 32'd1);
        lowph();
        check("t5_rst_vwe_lo", {31'd0, o_vwe_b}, 32'd1);
        check("t5_rst_vdata", {24'd0, o_vdata}, 32'h0);
        tick();
        i_rst = 1'b0;
        check("t5_busy", {31'd0, o_busy}, 32'd0);
        check("t5_full", {31'd0, o_fifo_full}, 32'd0);
        check("t5_ovf", {31'd0, o_overflow}, 32'd0);
        ncommit = 0;
        for (int c = 0; c < 30; c++) begin
            lowph();
            if (!o_vwe_b) begin
                ncommit++;
            end
            tick();
        end
        check("t5_no_commits_after_rst", 32'(ncommit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
